// File: rtl/crc_pkg.sv
// Shared CRC-14 definitions: field widths, generator polynomial and the
// checker state encoding used by the encoder/checker pair.
package crc_pkg;

  localparam int CRC_W     = 14;
  localparam int MSG_W     = 8;
  localparam int CW_W      = 22;
  localparam int BIT_CNT_W = $clog2(CW_W);

  // Low terms of x^14 + x^10 + x^8 + x^7 + x^4 + x^3 + 1 (x^14 implicit).
  localparam logic [CRC_W-1:0] CRC14_POLY = 14'h0599;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } chk_state_e;

endpackage

// File: rtl/crc14_step.sv
// One-bit CRC-14 LFSR update, shared by the encoder and the checker.
module crc14_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC14_POLY
) (
  input  logic [CRC_W-1:0] lfsr,
  input  logic             bit_in,
  output logic [CRC_W-1:0] lfsr_next
);

  logic fb;

  assign fb        = bit_in ^ lfsr[CRC_W-1];
  assign lfsr_next = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_checker.sv
// Bit-serial CRC-14 checker: accepts a {msg, crc} codeword, runs it MSB first
// through the LFSR and reports the syndrome with a saturating error count.
module crc_checker
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC14_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MSG_W-1:0] msg_out,
  output logic             crc_ok,
  output logic [CRC_W-1:0] syndrome,
  output logic [15:0]      err_count
);

  chk_state_e           state_q, state_d;
  logic [CW_W-1:0]      cw_q;
  logic [CRC_W-1:0]     lfsr_q;
  logic [CRC_W-1:0]     lfsr_next;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 fin_q;     // all 22 bits shifted; next edge registers the result
  logic [15:0]          err_cnt_q;

  crc14_step #(.POLY(POLY)) u_step (
    .lfsr      (lfsr_q),
    .bit_in    (cw_q[bit_cnt_q]),
    .lfsr_next (lfsr_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (fin_q) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured codeword is reset along with the rest; it is a plain
  // register, not a memory, so the reset costs nothing and keeps sim X-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q      <= '0;
      lfsr_q    <= '0;
      bit_cnt_q <= '0;
      fin_q     <= 1'b0;
      msg_out   <= '0;
      crc_ok    <= 1'b0;
      syndrome  <= '0;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            cw_q      <= codeword_in;
            lfsr_q    <= '0;
            bit_cnt_q <= BIT_CNT_W'(CW_W - 1);
            fin_q     <= 1'b0;
          end
        end
        SHIFT: begin
          if (!fin_q) begin
            lfsr_q <= lfsr_next;
            if (bit_cnt_q == '0) fin_q     <= 1'b1;
            else                 bit_cnt_q <= bit_cnt_q - 1'b1;
          end else begin
            syndrome <= lfsr_q;
            crc_ok   <= (lfsr_q == '0);
            msg_out  <= cw_q[CW_W-1 -: MSG_W];
            if (lfsr_q != '0 && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_crc_checker.sv
// Scoreboard bench for crc_checker: expected syndromes come from polynomial
// long division of the codeword, independent of the serial LFSR.
module tb_crc_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] codeword_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  msg_out;
  logic        crc_ok;
  logic [13:0] syndrome;
  logic [15:0] err_count;

  typedef struct packed {
    logic [7:0]  msg;
    logic        ok;
    logic [13:0] syn;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] err_model;
  int          n_tests = 0;
  int          n_fail  = 0;

  crc_checker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .codeword_in (codeword_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .msg_out     (msg_out),
    .crc_ok      (crc_ok),
    .syndrome    (syndrome),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // v mod (x^14 + POLY) by long division.
  function automatic logic [13:0] poly_mod(input logic [35:0] v);
    logic [35:0] r;
    logic [35:0] g;
    r = v;
    g = {21'b0, 1'b1, 14'h0599};
    for (int i = 35; i >= 14; i--)
      if (r[i]) r = r ^ (g << (i - 14));
    return r[13:0];
  endfunction

  function automatic logic [21:0] encode(input logic [7:0] msg);
    return {msg, poly_mod({14'b0, msg, 14'b0})};
  endfunction

  // Send one codeword, hold out_ready low for 'hold' DONE cycles, then check.
  task automatic process(input logic [21:0] cw, input int hold);
    exp_t        e;
    int          lat;
    logic        got;
    logic [7:0]  m;
    logic [13:0] s;
    logic        ok;
    logic [15:0] ec;
    @(negedge clk);
    codeword_in = cw;
    in_valid    = 1'b1;
    out_ready   = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (in_ready) got = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout cw=%h in_ready=%b required 1", cw, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.syn = poly_mod({cw, 14'b0});
    e.ok  = (e.syn == 14'd0);
    e.msg = cw[21:14];
    sb_q.push_back(e);
    if (!e.ok && err_model != 16'hFFFF) err_model++;

    // Keep in_valid high with a different word: must be ignored while busy.
    @(negedge clk);
    codeword_in = ~cw;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_in_ready got=%b required 0", in_ready);
    end

    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (lat != 23) begin
      n_fail++;
      $display("FAIL latency cw=%h got=%0d edges required 23", cw, lat);
    end
    if (!got) begin
      void'(sb_q.pop_front());
      out_ready = 1'b1;
      return;
    end

    if (hold > 0) begin
      m  = msg_out;
      s  = syndrome;
      ok = crc_ok;
      ec = err_count;
      for (int i = 0; i < hold; i++) begin
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || msg_out !== m ||
            syndrome !== s || crc_ok !== ok || err_count !== ec) begin
          n_fail++;
          $display("FAIL stall_stable cyc=%0d got v=%b r=%b m=%h s=%h ok=%b e=%h required v=1 r=0 m=%h s=%h ok=%b e=%h",
                   i, out_valid, in_ready, msg_out, syndrome, crc_ok, err_count, m, s, ok, ec);
        end
        @(posedge clk);
        @(negedge clk);
      end
      out_ready = 1'b1;
    end

    e = sb_q.pop_front();
    n_tests++;
    if (msg_out !== e.msg || crc_ok !== e.ok || syndrome !== e.syn) begin
      n_fail++;
      $display("FAIL result cw=%h got msg=%h ok=%b syn=%h required msg=%h ok=%b syn=%h",
               cw, msg_out, crc_ok, syndrome, e.msg, e.ok, e.syn);
    end
    n_tests++;
    if (err_count !== err_model) begin
      n_fail++;
      $display("FAIL err_count cw=%h got=%h required %h", cw, err_count, err_model);
    end

    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || msg_out !== 8'h00 ||
        crc_ok !== 1'b0 || syndrome !== 14'h0 || err_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got r=%b v=%b m=%h ok=%b s=%h e=%h required 1 0 00 0 0000 0000",
               in_ready, out_valid, msg_out, crc_ok, syndrome, err_count);
    end
  endtask

  task automatic test_directed();
    process(22'h000000, 0);
    process(22'h004599, 0);
    process(22'h004598, 0);
  endtask

  task automatic test_stall();
    process(encode(8'hA5), 10);
    process(encode(8'h3C) ^ 22'h000400, 10);
  endtask

  task automatic test_back_to_back();
    logic [21:0] cw;
    for (int i = 0; i < 6; i++) begin
      cw = encode(8'($urandom));
      if (i % 3 == 2) cw = cw ^ (22'd1 << $urandom_range(21, 0));
      process(cw, 0);
    end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    codeword_in = 22'h004598;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    err_model = 16'h0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_count !== 16'h0 || syndrome !== 14'h0) begin
      n_fail++;
      $display("FAIL mid_reset got r=%b v=%b e=%h s=%h required 1 0 0000 0000",
               in_ready, out_valid, err_count, syndrome);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || err_count !== 16'h0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d got v=%b e=%h r=%b required 0 0000 1",
                 i, out_valid, err_count, in_ready);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFD;
    #1;
    release dut.err_cnt_q;
    err_model = 16'hFFFD;
    for (int i = 0; i < 4; i++)
      process(encode(8'($urandom)) ^ (22'd1 << i), 0);
    n_tests++;
    if (err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate got=%h required FFFF", err_count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    codeword_in = '0;
    err_model   = 16'h0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid_shift();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
